// File: rtl/i_sram_like_to_axi_pkg.sv
// Shared AXI/sram-like constants and FSM state type for the instruction-side read bridge.
package i_sram_like_to_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    // sram-like size codes (0 byte, 1 half, 2 word) map directly onto AXI arsize
    function automatic logic [2:0] sram_to_axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/i_sram_like_to_axi.sv
// Instruction-side bridge: sram-like read slave to single-beat AXI read master, one read outstanding.
// Optional sticky non-OKAY response flag on axi_err is built when I_AXI_RESP_CHECK_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for an sram-like read request
// S_AR   | arvalid asserted, waiting for arready
// S_R    | rready asserted, waiting for the single R beat
module i_sram_like_to_axi
    import i_sram_like_to_axi_pkg::*;
#(
    parameter int              ID_W  = 4,
    parameter logic [ID_W-1:0] AR_ID = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [31:0]     inst_rdata,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic            axi_err
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_araddr;
    logic [1:0]  r_size;
    logic        w_accept;
    logic        w_resp_ok;
    logic        w_unused;

    assign w_accept  = (r_state == S_IDLE) && inst_req && !inst_wr;
    assign w_resp_ok = (rresp == AXI_RESP_OKAY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address and size only load in IDLE, so they stay stable for the whole AR wait.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_araddr <= '0;
            r_size   <= '0;
        end else if (w_accept) begin
            r_araddr <= inst_addr;
            r_size   <= inst_size;
        end
    end

    always_comb begin
        w_next_state = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_AR;
            end
            S_AR: begin
                arvalid      = 1'b1;
                inst_addr_ok = arready;
                if (arready) w_next_state = S_R;
            end
            S_R: begin
                rready       = 1'b1;
                inst_data_ok = rvalid;
                if (rvalid) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign inst_rdata = rdata;
    assign arid       = AR_ID;
    assign araddr     = r_araddr;
    assign arlen      = 8'd0;
    assign arsize     = sram_to_axi_size(r_size);
    assign arburst    = AXI_BURST_INCR;
    assign arlock     = 2'b00;
    assign arcache    = 4'b0000;
    assign arprot     = 3'b000;

`ifdef I_AXI_RESP_CHECK_EN
    logic r_axi_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_axi_err <= 1'b0;
        end else if (rvalid && rready && !w_resp_ok) begin
            r_axi_err <= 1'b1;
        end
    end

    assign axi_err  = r_axi_err;
    assign w_unused = ^{inst_wdata, rid, rlast};
`else
    assign axi_err  = 1'b0;
    assign w_unused = ^{inst_wdata, rid, rlast, w_resp_ok};
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && (r_state == S_IDLE) && inst_req && inst_wr)
            $error("i_sram_like_to_axi: write request on read-only bridge");
        if (resetn && (r_state == S_R) && rvalid && !rlast)
            $error("i_sram_like_to_axi: single-beat read returned rlast=0");
    end
`endif

endmodule
